// File: rtl/eth_rx_pkg.sv
// Shared types and constants for the GMII receive frame path.
package eth_rx_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRE,
        DATA,
        DROP
    } rx_state_t;

    localparam logic [7:0] ETH_PREAMBLE = 8'h55;
    localparam logic [7:0] ETH_SFD      = 8'hD5;
    localparam int         LEN_W        = 11;

endpackage

// File: rtl/eth_stat_cnt.sv
// Wrapping statistics counter with synchronous clear.
module eth_stat_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (clr) begin
            count_reg <= '0;
        end else if (inc) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/gmii_rx_frame_ctrl.sv
// GMII receive sequencer: strips preamble/SFD, delimits frames, flags runt and
// oversize frames and keeps good/error frame statistics.
module gmii_rx_frame_ctrl
    import eth_rx_pkg::*;
#(
    parameter int MIN_PRE = 2,
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1518,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx_en,
    input  logic             gmii_rx_dv,
    input  logic [7:0]       gmii_rxd,
    output logic             rx_valid,
    output logic [7:0]       rx_data,
    output logic             rx_sof,
    output logic             rx_eof,
    output logic             rx_err,
    output logic             rx_busy,
    output logic [CNT_W-1:0] good_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    rx_state_t        state_reg, state_next;
    logic [2:0]       pre_cnt_reg, pre_cnt_next;
    logic [LEN_W-1:0] len_reg, len_next;
    logic [7:0]       hold_data_reg, hold_data_next;
    logic             hold_full_reg, hold_full_next;
    logic             first_reg, first_next;

    logic             valid_reg, valid_next;
    logic [7:0]       data_reg, data_next;
    logic             sof_reg, sof_next;
    logic             eof_reg, eof_next;
    logic             err_reg, err_next;

    // index 0 = good frames, index 1 = errored frames / dropped preambles
    logic [1:0]       cnt_inc;
    logic [CNT_W-1:0] cnt_val [2];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            pre_cnt_reg   <= '0;
            len_reg       <= '0;
            hold_data_reg <= '0;
            hold_full_reg <= 1'b0;
            first_reg     <= 1'b0;
            valid_reg     <= 1'b0;
            data_reg      <= '0;
            sof_reg       <= 1'b0;
            eof_reg       <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            pre_cnt_reg   <= pre_cnt_next;
            len_reg       <= len_next;
            hold_data_reg <= hold_data_next;
            hold_full_reg <= hold_full_next;
            first_reg     <= first_next;
            valid_reg     <= valid_next;
            data_reg      <= data_next;
            sof_reg       <= sof_next;
            eof_reg       <= eof_next;
            err_reg       <= err_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        pre_cnt_next   = pre_cnt_reg;
        len_next       = len_reg;
        hold_data_next = hold_data_reg;
        hold_full_next = hold_full_reg;
        first_next     = first_reg;
        valid_next     = 1'b0;
        data_next      = data_reg;
        sof_next       = 1'b0;
        eof_next       = 1'b0;
        err_next       = 1'b0;
        cnt_inc        = 2'b00;

        case (state_reg)
            IDLE: begin
                if (gmii_rx_dv) begin
                    if (rx_en && gmii_rxd == ETH_PREAMBLE) begin
                        state_next   = PRE;
                        pre_cnt_next = 3'd1;
                    end else begin
                        state_next = DROP;
                    end
                end
            end

            PRE: begin
                if (!gmii_rx_dv) begin
                    state_next = IDLE;
                    cnt_inc[1] = 1'b1;
                end else if (gmii_rxd == ETH_PREAMBLE) begin
                    if (pre_cnt_reg != 3'd7) begin
                        pre_cnt_next = pre_cnt_reg + 3'd1;
                    end
                end else if (gmii_rxd == ETH_SFD && pre_cnt_reg >= 3'(MIN_PRE)) begin
                    state_next     = DATA;
                    len_next       = '0;
                    hold_full_next = 1'b0;
                    first_next     = 1'b1;
                end else begin
                    state_next = DROP;
                    cnt_inc[1] = 1'b1;
                end
            end

            DATA: begin
                if (gmii_rx_dv) begin
                    if (len_reg == LEN_W'(MAX_LEN)) begin
                        // Oversize: close the frame on the held byte, discard the rest.
                        valid_next     = 1'b1;
                        data_next      = hold_data_reg;
                        sof_next       = first_reg;
                        eof_next       = 1'b1;
                        err_next       = 1'b1;
                        cnt_inc[1]     = 1'b1;
                        hold_full_next = 1'b0;
                        first_next     = 1'b0;
                        state_next     = DROP;
                    end else begin
                        hold_data_next = gmii_rxd;
                        hold_full_next = 1'b1;
                        len_next       = len_reg + 1'b1;
                        if (hold_full_reg) begin
                            valid_next = 1'b1;
                            data_next  = hold_data_reg;
                            sof_next   = first_reg;
                            first_next = 1'b0;
                        end
                    end
                end else begin
                    // dv gap: the held byte is the true last byte of the frame.
                    if (hold_full_reg) begin
                        valid_next = 1'b1;
                        data_next  = hold_data_reg;
                        sof_next   = first_reg;
                        eof_next   = 1'b1;
                        err_next   = (len_reg < LEN_W'(MIN_LEN));
                        cnt_inc[0] = !(len_reg < LEN_W'(MIN_LEN));
                        cnt_inc[1] = (len_reg < LEN_W'(MIN_LEN));
                    end else begin
                        cnt_inc[1] = 1'b1;
                    end
                    hold_full_next = 1'b0;
                    first_next     = 1'b0;
                    state_next     = IDLE;
                end
            end

            DROP: begin
                if (!gmii_rx_dv) begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_stat
            eth_stat_cnt #(
                .W(CNT_W)
            ) u_cnt (
                .clk  (clk),
                .clr  (rst),
                .inc  (cnt_inc[gi]),
                .count(cnt_val[gi])
            );
        end
    endgenerate

    assign rx_valid = valid_reg;
    assign rx_data  = data_reg;
    assign rx_sof   = sof_reg;
    assign rx_eof   = eof_reg;
    assign rx_err   = err_reg;
    assign rx_busy  = (state_reg != IDLE);
    assign good_cnt = cnt_val[0];
    assign err_cnt  = cnt_val[1];

endmodule

// File: tb/tb_gmii_rx_frame_ctrl.sv
// Directed bench for gmii_rx_frame_ctrl: frame delimiting, length limits,
// enable gating, reset abort and back-to-back frames.
module tb_gmii_rx_frame_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_en;
    logic        gmii_rx_dv;
    logic [7:0]  gmii_rxd;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_sof;
    logic        rx_eof;
    logic        rx_err;
    logic        rx_busy;
    logic [15:0] good_cnt;
    logic [15:0] err_cnt;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int first_data_cyc = 0;
    int marker_viol = 0;

    logic [7:0] q_data[$];
    bit         q_sof[$];
    bit         q_eof[$];
    bit         q_err[$];
    int         q_cyc[$];

    gmii_rx_frame_ctrl #(
        .MIN_PRE(2),
        .MIN_LEN(64),
        .MAX_LEN(1518),
        .CNT_W  (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_en     (rx_en),
        .gmii_rx_dv(gmii_rx_dv),
        .gmii_rxd  (gmii_rxd),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .rx_sof    (rx_sof),
        .rx_eof    (rx_eof),
        .rx_err    (rx_err),
        .rx_busy   (rx_busy),
        .good_cnt  (good_cnt),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Capture every output beat on the falling edge.
    always @(negedge clk) begin
        if (rx_valid === 1'b1) begin
            q_data.push_back(rx_data);
            q_sof.push_back(rx_sof);
            q_eof.push_back(rx_eof);
            q_err.push_back(rx_err);
            q_cyc.push_back(cyc);
        end
        if (rx_valid === 1'b0 && (rx_sof | rx_eof | rx_err) !== 1'b0) begin
            marker_viol++;
        end
    end

    task automatic clear_q();
        q_data.delete();
        q_sof.delete();
        q_eof.delete();
        q_err.delete();
        q_cyc.delete();
    endtask

    task automatic drive(input logic dv, input logic [7:0] d);
        gmii_rx_dv = dv;
        gmii_rxd   = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(1'b0, 8'h00);
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        rx_en = 1'b1;
        idle(2);
        rst = 1'b0;
        clear_q();
    endtask

    // Preamble, SFD, payload bytes 0,1,2.. (mod 256), then one idle cycle.
    task automatic send_frame(input int npre, input int nbytes, input int en_off_at);
        for (int p = 0; p < npre; p++) drive(1'b1, 8'h55);
        drive(1'b1, 8'hD5);
        for (int i = 0; i < nbytes; i++) begin
            if (i == en_off_at) rx_en = 1'b0;
            if (i == 0) first_data_cyc = cyc;
            drive(1'b1, 8'(i));
        end
        drive(1'b0, 8'h00);
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        rx_en      = 1'b1;
        gmii_rx_dv = 1'b0;
        gmii_rxd   = 8'h00;
        idle(3);
        checks++;
        if (rx_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b want=0", rx_valid); end
        checks++;
        if (rx_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", rx_busy); end
        checks++;
        if (good_cnt !== 16'd0 || err_cnt !== 16'd0) begin
            failures++; $display("FAIL reset_cnt got good=%0d err=%0d want 0/0", good_cnt, err_cnt);
        end
        rst = 1'b0;
        clear_q();
        $display("test_reset done");
    endtask

    task automatic test_good_frame();
        do_reset();
        send_frame(7, 64, -1);
        idle(3);
        $display("frame good64 beats=%0d good=%0d err=%0d", q_data.size(), good_cnt, err_cnt);
        checks++;
        if (q_data.size() != 64) begin failures++; $display("FAIL good_beats got=%0d want=64", q_data.size()); end
        for (int n = 0; n < q_data.size(); n++) begin
            checks++;
            if (q_data[n] !== 8'(n) || q_sof[n] !== (n == 0) || q_eof[n] !== (n == 63) || q_err[n] !== 1'b0) begin
                failures++;
                $display("FAIL good_beat%0d got d=%02h s=%b e=%b r=%b want d=%02h s=%b e=%b r=0",
                         n, q_data[n], q_sof[n], q_eof[n], q_err[n], 8'(n), n == 0, n == 63);
            end
        end
        checks++;
        if (q_cyc.size() == 0 || q_cyc[0] != first_data_cyc + 2) begin
            failures++; $display("FAIL good_latency got=%0d want=%0d", q_cyc.size() ? q_cyc[0] : -1, first_data_cyc + 2);
        end
        checks++;
        if (good_cnt !== 16'd1 || err_cnt !== 16'd0) begin
            failures++; $display("FAIL good_cnt got good=%0d err=%0d want 1/0", good_cnt, err_cnt);
        end
    endtask

    task automatic test_runt();
        do_reset();
        send_frame(7, 60, -1);
        idle(3);
        $display("frame runt60 beats=%0d good=%0d err=%0d", q_data.size(), good_cnt, err_cnt);
        checks++;
        if (q_data.size() != 60) begin failures++; $display("FAIL runt_beats got=%0d want=60", q_data.size()); end
        checks++;
        if (q_data.size() == 0 || q_eof[q_data.size()-1] !== 1'b1 || q_err[q_data.size()-1] !== 1'b1
            || q_data[q_data.size()-1] !== 8'h3B) begin
            failures++; $display("FAIL runt_last expected eof=1 err=1 data=3b");
        end
        checks++;
        if (good_cnt !== 16'd0 || err_cnt !== 16'd1) begin
            failures++; $display("FAIL runt_cnt got good=%0d err=%0d want 0/1", good_cnt, err_cnt);
        end
    endtask

    task automatic test_one_byte();
        do_reset();
        send_frame(7, 1, -1);
        idle(3);
        $display("frame one_byte beats=%0d", q_data.size());
        checks++;
        if (q_data.size() != 1 || q_sof[0] !== 1'b1 || q_eof[0] !== 1'b1 || q_err[0] !== 1'b1 || q_data[0] !== 8'h00) begin
            failures++; $display("FAIL one_byte got beats=%0d want single beat sof=eof=err=1 data=00", q_data.size());
        end
    endtask

    task automatic test_oversize();
        do_reset();
        for (int p = 0; p < 7; p++) drive(1'b1, 8'h55);
        drive(1'b1, 8'hD5);
        for (int i = 0; i < 1600; i++) drive(1'b1, 8'(i));
        checks++;
        if (rx_busy !== 1'b1) begin failures++; $display("FAIL over_busy got=%b want=1", rx_busy); end
        idle(1);
        checks++;
        if (rx_busy !== 1'b0) begin failures++; $display("FAIL over_idle got=%b want=0", rx_busy); end
        idle(2);
        $display("frame oversize1600 beats=%0d good=%0d err=%0d", q_data.size(), good_cnt, err_cnt);
        checks++;
        if (q_data.size() != 1518) begin failures++; $display("FAIL over_beats got=%0d want=1518", q_data.size()); end
        for (int n = 0; n < q_data.size(); n++) begin
            checks++;
            if (q_data[n] !== 8'(n) || q_sof[n] !== (n == 0) || q_eof[n] !== (n == 1517) || q_err[n] !== (n == 1517)) begin
                failures++;
                $display("FAIL over_beat%0d got d=%02h s=%b e=%b r=%b", n, q_data[n], q_sof[n], q_eof[n], q_err[n]);
            end
        end
        checks++;
        if (good_cnt !== 16'd0 || err_cnt !== 16'd1) begin
            failures++; $display("FAIL over_cnt got good=%0d err=%0d want 0/1", good_cnt, err_cnt);
        end
    endtask

    task automatic test_short_preamble();
        do_reset();
        drive(1'b1, 8'h55);
        drive(1'b1, 8'hD5);
        drive(1'b1, 8'h11);
        drive(1'b1, 8'h22);
        drive(1'b0, 8'h00);
        idle(1);
        checks++;
        if (q_data.size() != 0 || err_cnt !== 16'd1) begin
            failures++; $display("FAIL shortpre_drop got beats=%0d err=%0d want 0/1", q_data.size(), err_cnt);
        end
        send_frame(7, 64, -1);
        idle(3);
        $display("frame after_shortpre beats=%0d good=%0d err=%0d", q_data.size(), good_cnt, err_cnt);
        checks++;
        if (q_data.size() != 64 || q_sof[0] !== 1'b1 || q_data[0] !== 8'h00 || q_eof[63] !== 1'b1 || q_err[63] !== 1'b0) begin
            failures++; $display("FAIL shortpre_next got beats=%0d want 64 clean", q_data.size());
        end
        checks++;
        if (good_cnt !== 16'd1 || err_cnt !== 16'd1) begin
            failures++; $display("FAIL shortpre_cnt got good=%0d err=%0d want 1/1", good_cnt, err_cnt);
        end
    endtask

    task automatic test_rx_en();
        do_reset();
        rx_en = 1'b0;
        send_frame(7, 64, -1);
        idle(3);
        $display("frame disabled beats=%0d good=%0d err=%0d", q_data.size(), good_cnt, err_cnt);
        checks++;
        if (q_data.size() != 0 || good_cnt !== 16'd0 || err_cnt !== 16'd0) begin
            failures++; $display("FAIL en_off got beats=%0d good=%0d err=%0d want 0/0/0", q_data.size(), good_cnt, err_cnt);
        end
        rx_en = 1'b1;
        send_frame(7, 64, 10);
        idle(3);
        $display("frame en_drop_mid beats=%0d good=%0d err=%0d", q_data.size(), good_cnt, err_cnt);
        checks++;
        if (q_data.size() != 64 || q_eof[63] !== 1'b1 || q_err[63] !== 1'b0 || good_cnt !== 16'd1) begin
            failures++; $display("FAIL en_mid got beats=%0d good=%0d want 64/1", q_data.size(), good_cnt);
        end
        send_frame(7, 64, -1);
        idle(3);
        checks++;
        if (q_data.size() != 64 || good_cnt !== 16'd1 || err_cnt !== 16'd0) begin
            failures++; $display("FAIL en_next got beats=%0d good=%0d err=%0d want 64/1/0", q_data.size(), good_cnt, err_cnt);
        end
        rx_en = 1'b1;
    endtask

    task automatic test_rst_mid();
        do_reset();
        send_frame(7, 64, -1);
        idle(2);
        checks++;
        if (good_cnt !== 16'd1) begin failures++; $display("FAIL rstmid_pre got good=%0d want=1", good_cnt); end
        for (int p = 0; p < 7; p++) drive(1'b1, 8'h55);
        drive(1'b1, 8'hD5);
        for (int i = 0; i < 30; i++) drive(1'b1, 8'(i));
        rst = 1'b1;
        drive(1'b1, 8'd30);
        checks++;
        if (rx_valid !== 1'b0 || rx_busy !== 1'b0 || good_cnt !== 16'd0 || err_cnt !== 16'd0) begin
            failures++; $display("FAIL rstmid_abort got v=%b busy=%b good=%0d err=%0d want 0/0/0/0",
                                 rx_valid, rx_busy, good_cnt, err_cnt);
        end
        rst = 1'b0;
        drive(1'b0, 8'h00);
        clear_q();
        send_frame(7, 64, -1);
        idle(3);
        $display("frame after_rst beats=%0d good=%0d err=%0d", q_data.size(), good_cnt, err_cnt);
        checks++;
        if (q_data.size() != 64 || q_sof[0] !== 1'b1 || q_data[0] !== 8'h00 || good_cnt !== 16'd1 || err_cnt !== 16'd0) begin
            failures++; $display("FAIL rstmid_next got beats=%0d good=%0d err=%0d want 64/1/0", q_data.size(), good_cnt, err_cnt);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        send_frame(7, 64, -1);
        send_frame(2, 64, -1);
        idle(3);
        $display("frames back_to_back beats=%0d good=%0d err=%0d", q_data.size(), good_cnt, err_cnt);
        checks++;
        if (q_data.size() != 128) begin failures++; $display("FAIL b2b_beats got=%0d want=128", q_data.size()); end
        for (int n = 0; n < q_data.size(); n++) begin
            checks++;
            if (q_data[n] !== 8'(n % 64) || q_sof[n] !== (n % 64 == 0) || q_eof[n] !== (n % 64 == 63) || q_err[n] !== 1'b0) begin
                failures++;
                $display("FAIL b2b_beat%0d got d=%02h s=%b e=%b r=%b", n, q_data[n], q_sof[n], q_eof[n], q_err[n]);
            end
        end
        checks++;
        if (good_cnt !== 16'd2 || err_cnt !== 16'd0) begin
            failures++; $display("FAIL b2b_cnt got good=%0d err=%0d want 2/0", good_cnt, err_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_runt();
        test_one_byte();
        test_oversize();
        test_short_preamble();
        test_rx_en();
        test_rst_mid();
        test_back_to_back();
        checks++;
        if (marker_viol != 0) begin
            failures++; $display("FAIL marker_qual got=%0d markers without rx_valid want=0", marker_viol);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
